posit_precision_governor: RTL and testbench
===========================================

// Module: posit_precision_governor
// PURPOSE
//  Downstream consumer of fault_checker. Accepts posit add requests over valid/ready.
//  Drives the checker operands and samples fault/mode/sums.
//  Returns the truncated sum while truncation is trusted, or the full-precision sum after a fault.
//  After a fault, holds full precision for a window of operations; locks to full precision
//  once repeated faults reach a threshold.
// PARAMETERS
//  FULL_NBITS   32  posit width of operands/results
//  SCALE_W      7   width of checker scale fields
//  HOLD_OPS     4   ops kept in FULL mode after a fault (>=1)
//  LOCK_THRESH  8   fault count that sets sticky lock (1..255)
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  in_valid       in   1           request valid
//  in_ready       out  1           request accepted when in_valid&in_ready
//  in_a, in_b     in   FULL_NBITS  posit operands
//  chk_a, chk_b   out  FULL_NBITS  registered operands to fault_checker
//  chk_fault      in   1           checker fault flag
//  chk_true_sum   in   FULL_NBITS  checker full-precision sum
//  chk_used_sum   in   FULL_NBITS  checker truncated sum
//  chk_true_scale in   SCALE_W     scale of true_sum
//  chk_used_scale in   SCALE_W     scale of used_sum
//  out_valid      out  1           result valid
//  out_ready      in   1           result consumed when out_valid&out_ready
//  out_sum        out  FULL_NBITS  selected result
//  out_scale      out  SCALE_W     scale of the selected result
//  out_full       out  1           1 = out_sum is the full-precision sum
//  out_fault      out  1           checker faulted on this op
//  full_mode      out  1           governor currently in FULL mode
//  locked         out  1           sticky full-precision lock
//  fault_cnt      out  8           saturating fault count
//  clr_stats      in   1           sync pulse: clears fault_cnt and locked; only in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; in_ready=1; state IDLE; window counter=0; chk_a/chk_b=0.
//  FSM IDLE->EVAL->(RECOMP)->OUT->IDLE. One op in flight; in_ready=1 only in IDLE.
//  IDLE: on in_valid, register in_a/in_b into chk_a/chk_b and go to EVAL.
//  EVAL: sample checker outputs.
//   - FULL mode or locked: take true_sum/true_scale, out_full=1, go to OUT.
//   - TRUNC mode, no fault: take used_sum/used_scale, out_full=0, go to OUT.
//   - TRUNC mode, fault: go to RECOMP (1-cycle penalty). RECOMP takes true_sum/true_scale,
//     sets out_full=1, then goes to OUT.
//  Latency from accept to out_valid: 2 cycles, or 3 cycles on a TRUNC-mode fault.
//  OUT: out_valid=1. Outputs stay stable until out_ready, then return to IDLE.
//  Any fault seen in EVAL (any mode):
//   - out_fault=1;
//   - fault_cnt increments, saturating at 255;
//   - window reloads to HOLD_OPS;
//   - locked sets when fault_cnt+1 >= LOCK_THRESH.
//  Window: decrements by 1 on each completed op (out handshake) with no fault.
//   full_mode = (window!=0) | locked. Mode is evaluated at EVAL, not at accept.
//  clr_stats outside IDLE is ignored. In IDLE it has priority; it never clears the window.
//  Reset mid-operation: abandon the op, no out_valid, return to the reset state.
// STRUCTURE
//  Shared package: FSM state encoding (S_IDLE, S_EVAL, S_RECOMP, S_OUT).
//  Shared package also holds the FULL_NBITS/SCALE_W defaults shared with fault_checker.
//  No sub-modules: fault_checker is instantiated by the parent, not here.
// TESTING
//  Bench drives the chk_* inputs from a scripted checker stub.
//  1 Reset then A=40000000 B=40000000, stub used=true=48000000, fault=0
//    -> out_valid at +2, out_sum=48000000, out_full=0.
//  2 TRUNC op, stub fault=1, true=4C000000, used=4B000000
//    -> RECOMP taken, out_valid at +3, out_sum=4C000000, out_full=1, fault_cnt=1, full_mode=1.
//  3 After test 2 with HOLD_OPS=4, four fault-free ops
//    -> each out_full=1 at +2. Fifth op returns used_sum with full_mode=0.
//  4 LOCK_THRESH faults back-to-back -> locked=1 and stays 1 after 10 clean ops.
//    Then clr_stats in IDLE -> locked=0, fault_cnt=0.
//  5 Hold out_ready=0 for 5 cycles -> out_sum stable, in_ready=0. Release -> IDLE next cycle.
//  6 Assert rst during EVAL -> all outputs 0, in_ready=1, no out_valid pulse.

Source files
------------

// File: rtl/posit_precision_governor_pkg.sv
// Shared types and defaults for the posit precision governor and its fault_checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package posit_precision_governor_pkg;

  // Operand/result width and scale-field width shared with fault_checker
  localparam int FULL_NBITS_DEF = 32;
  localparam int SCALE_W_DEF    = 7;

  // One op in flight: accept, evaluate, optional recompute, present result
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_RECOMP = 2'd2,
    S_OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/posit_precision_governor.sv
// Selects truncated or full-precision posit sum from fault_checker; holds FULL after faults, locks on repeats.
// Latency: accept to out_valid is 2 cycles, or 3 when a TRUNC-mode op faults (recompute cycle).
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
module posit_precision_governor
  import posit_precision_governor_pkg::*;
#(
  parameter int FULL_NBITS  = FULL_NBITS_DEF,
  parameter int SCALE_W     = SCALE_W_DEF,
  parameter int HOLD_OPS    = 4,
  parameter int LOCK_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FULL_NBITS-1:0] in_a,
  input  logic [FULL_NBITS-1:0] in_b,
  output logic [FULL_NBITS-1:0] chk_a,
  output logic [FULL_NBITS-1:0] chk_b,
  input  logic                  chk_fault,
  input  logic [FULL_NBITS-1:0] chk_true_sum,
  input  logic [FULL_NBITS-1:0] chk_used_sum,
  input  logic [SCALE_W-1:0]    chk_true_scale,
  input  logic [SCALE_W-1:0]    chk_used_scale,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULL_NBITS-1:0] out_sum,
  output logic [SCALE_W-1:0]    out_scale,
  output logic                  out_full,
  output logic                  out_fault,
  output logic                  full_mode,
  output logic                  locked,
  output logic [7:0]            fault_cnt,
  input  logic                  clr_stats
);

  localparam int              WIN_W   = $clog2(HOLD_OPS + 1);
  localparam logic [WIN_W-1:0] HOLD_LD = WIN_W'(HOLD_OPS);
  localparam logic [8:0]       LOCK_TH = 9'(LOCK_THRESH);

  state_t           state_q;
  state_t           state_d;
  logic [WIN_W-1:0] window_q;
  logic             accept;
  logic             done;
  logic             eval_fault;
  logic [8:0]       fault_cnt_inc;

  assign accept        = (state_q == S_IDLE) && in_valid;
  assign done          = (state_q == S_OUT) && out_ready;
  assign eval_fault    = (state_q == S_EVAL) && chk_fault;
  assign fault_cnt_inc = {1'b0, fault_cnt} + 9'd1;

  // Mode is read at EVAL, so a fault on one op only affects the ops after it
  assign full_mode = (window_q != '0) | locked;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a fault in TRUNC mode costs one recompute cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_EVAL;
      S_EVAL:   state_d = (!full_mode && chk_fault) ? S_RECOMP : S_OUT;
      S_RECOMP: state_d = S_OUT;
      S_OUT:    if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
  end

  // Capture operands toward the checker on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_a <= '0;
      chk_b <= '0;
    end else if (accept) begin
      chk_a <= in_a;
      chk_b <= in_b;
    end
  end

  // Latch the selected result; held untouched through OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_scale <= '0;
      out_full  <= 1'b0;
      out_fault <= 1'b0;
    end else begin
      case (state_q)
        S_EVAL: begin
          out_fault <= chk_fault;
          if (full_mode) begin
            out_sum   <= chk_true_sum;
            out_scale <= chk_true_scale;
            out_full  <= 1'b1;
          end else if (!chk_fault) begin
            out_sum   <= chk_used_sum;
            out_scale <= chk_used_scale;
            out_full  <= 1'b0;
          end
        end
        S_RECOMP: begin
          out_sum   <= chk_true_sum;
          out_scale <= chk_true_scale;
          out_full  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fault statistics: saturating count and sticky lock; clear only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt <= '0;
      locked    <= 1'b0;
    end else if ((state_q == S_IDLE) && clr_stats) begin
      fault_cnt <= '0;
      locked    <= 1'b0;
    end else if (eval_fault) begin
      if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt_inc[7:0];
      if (fault_cnt_inc >= LOCK_TH) locked <= 1'b1;
    end
  end

  // Hold window: reload on fault, count down on each clean completed op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
    end else if (eval_fault) begin
      window_q <= HOLD_LD;
    end else if (done && !out_fault && (window_q != '0)) begin
      window_q <= window_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_posit_precision_governor.sv
// Directed bench for posit_precision_governor with a scripted checker stub and result scoreboard.
// Latency: n/a.
// Backpressure: exercises held out_ready and reset mid-operation.
module tb_posit_precision_governor;

  localparam int HOLD_OPS    = 4;
  localparam int LOCK_THRESH = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] chk_a, chk_b;
  logic        chk_fault;
  logic [31:0] chk_true_sum, chk_used_sum;
  logic [6:0]  chk_true_scale, chk_used_scale;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [6:0]  out_scale;
  logic        out_full, out_fault, full_mode, locked;
  logic [7:0]  fault_cnt;
  logic        clr_stats;

  posit_precision_governor #(
    .FULL_NBITS (32),
    .SCALE_W    (7),
    .HOLD_OPS   (HOLD_OPS),
    .LOCK_THRESH(LOCK_THRESH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .chk_a         (chk_a),
    .chk_b         (chk_b),
    .chk_fault     (chk_fault),
    .chk_true_sum  (chk_true_sum),
    .chk_used_sum  (chk_used_sum),
    .chk_true_scale(chk_true_scale),
    .chk_used_scale(chk_used_scale),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_scale     (out_scale),
    .out_full      (out_full),
    .out_fault     (out_fault),
    .full_mode     (full_mode),
    .locked        (locked),
    .fault_cnt     (fault_cnt),
    .clr_stats     (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic [6:0]  scale;
    logic        full;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model of the governor's mode state
  int m_win    = 0;
  int m_cnt    = 0;
  bit m_locked = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(m_cnt));
    chk({tag, "_locked"},    32'(locked),    32'(m_locked));
    chk({tag, "_full_mode"}, 32'(full_mode), 32'((m_win != 0) || m_locked));
  endtask

  // One request through the DUT; stub answers with the given checker results.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic f,
                        input logic [31:0] ts, input logic [31:0] us,
                        input logic [6:0] tsc, input logic [6:0] usc, input int hold);
    exp_t e;
    exp_t got;
    int   n;
    bit   m_full;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid       = 1'b1;
    in_a           = a;
    in_b           = b;
    chk_fault      = f;
    chk_true_sum   = ts;
    chk_used_sum   = us;
    chk_true_scale = tsc;
    chk_used_scale = usc;
    m_full = (m_win != 0) || m_locked;
    if (m_full) begin
      e.sum = ts; e.scale = tsc; e.full = 1'b1; e.lat = 2;
    end else if (!f) begin
      e.sum = us; e.scale = usc; e.full = 1'b0; e.lat = 2;
    end else begin
      e.sum = ts; e.scale = tsc; e.full = 1'b1; e.lat = 3;
    end
    e.fault = f;
    sb.push_back(e);
    if (f) begin
      if (m_cnt + 1 >= LOCK_THRESH) m_locked = 1;
      if (m_cnt != 255) m_cnt++;
      m_win = HOLD_OPS;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    chk("chk_a", chk_a, a);
    chk("chk_b", chk_b, b);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    chk("latency",   32'(n),         32'(got.lat));
    chk("out_sum",   out_sum,        got.sum);
    chk("out_scale", 32'(out_scale), 32'(got.scale));
    chk("out_full",  32'(out_full),  32'(got.full));
    chk("out_fault", 32'(out_fault), 32'(got.fault));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_sum",       out_sum,         got.sum);
      chk("hold_valid",     32'(out_valid),  32'd1);
      chk("hold_in_ready",  32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (!f && m_win != 0) m_win--;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle",     32'(in_ready),  32'd1);
    chk("out_valid_low", 32'(out_valid), 32'd0);
    chk_stats("post_op");
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_stats = 1'b1;
    @(posedge clk);
    m_cnt    = 0;
    m_locked = 0;
    @(negedge clk);
    clr_stats = 1'b0;
    chk_stats("clr");
  endtask

  // Bound the whole run in case the DUT wedges
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    chk_fault = 1'b0; chk_true_sum = '0; chk_used_sum = '0;
    chk_true_scale = '0; chk_used_scale = '0;
    out_ready = 1'b0; clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   out_sum,        32'd0);
    chk("rst_out_full",  32'(out_full),  32'd0);
    chk("rst_chk_a",     chk_a,          32'd0);
    chk_stats("rst");

    // 1: clean TRUNC op
    run_op(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4800_0000, 32'h4800_0000, 7'd2, 7'd2, 0);

    // 2: TRUNC-mode fault takes the recompute path
    run_op(32'h4400_0000, 32'h4200_0000, 1'b1, 32'h4C00_0000, 32'h4B00_0000, 7'd3, 7'd2, 0);

    // 3: window of HOLD_OPS clean ops in FULL, then back to TRUNC
    for (int i = 0; i < HOLD_OPS + 1; i++)
      run_op(32'h3000_0000 + 32'(i), 32'h2000_0000, 1'b0,
             32'h4800_0010 + 32'(i * 16), 32'h4800_000F + 32'(i * 16), 7'd5, 7'd4, 0);

    // 4: LOCK_THRESH faults lock; lock survives clean ops; clr_stats releases it
    do_clr();
    for (int i = 0; i < LOCK_THRESH; i++)
      run_op(32'h5000_0000 + 32'(i), 32'h1000_0000, 1'b1,
             32'h5A00_0000 + 32'(i), 32'h5900_0000 + 32'(i), 7'd9, 7'd8, 0);
    for (int i = 0; i < 10; i++)
      run_op(32'h6000_0000 + 32'(i), 32'h0100_0000, 1'b0,
             32'h6100_0000 + 32'(i), 32'h60FF_0000 + 32'(i), 7'd11, 7'd10, 0);
    do_clr();
    run_op(32'h7000_0000, 32'h0200_0000, 1'b0, 32'h7100_0000, 32'h70FF_0000, 7'd12, 7'd13, 0);

    // 5: held out_ready on a faulting op
    run_op(32'h3800_0000, 32'h3900_0000, 1'b1, 32'h4D00_0000, 32'h4E00_0000, 7'd6, 7'd1, 5);

    // 6: reset while in EVAL abandons the op
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h0BAD_F00D; chk_fault = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    m_win = 0; m_cnt = 0; m_locked = 0;
    chk("rst6_in_ready",  32'(in_ready),  32'd1);
    chk("rst6_out_valid", 32'(out_valid), 32'd0);
    chk("rst6_out_sum",   out_sum,        32'd0);
    chk("rst6_out_fault", 32'(out_fault), 32'd0);
    chk("rst6_chk_a",     chk_a,          32'd0);
    chk_stats("rst6");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst6_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(32'h4000_0000, 32'h3000_0000, 1'b0, 32'h4700_0000, 32'h4680_0000, 7'd7, 7'd6, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
